// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: the next-PC select
// encoding and the control-priority decode that produces it.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_RET    = 3'd1,
        SEL_CALL   = 3'd2,
        SEL_JUMP   = 3'd3,
        SEL_BRANCH = 3'd4,
        SEL_INC    = 3'd5
    } pc_sel_e;

    // Only the highest-priority asserted control wins; the rest are dropped.
    // Ordering: stall > ret > call > jump > branch > increment.
    function automatic pc_sel_e pc_select(
        input logic stall,
        input logic ret,
        input logic call,
        input logic jump,
        input logic branch
    );
        pc_sel_e sel;
        if (stall)       sel = SEL_HOLD;
        else if (ret)    sel = SEL_RET;
        else if (call)   sel = SEL_CALL;
        else if (jump)   sel = SEL_JUMP;
        else if (branch) sel = SEL_BRANCH;
        else             sel = SEL_INC;
        return sel;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the decode unit (master) and the PC
// sequencer (slave).
//
// Handshake: there is no valid/ready pair. Every control is level-sampled on
// each rising clk edge and the sequencer always accepts it; stall is the only
// back-pressure and it is driven by the master. Status outputs are registered.
interface pc_sequencer_if #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic              stall;
    logic              jump;
    logic              branch;
    logic [ADDR_W-1:0] offset;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic [SP_W-1:0]   sp;
    logic              stack_full;
    logic              stack_empty;
    logic              fault;

    modport master (
        output stall, jump, branch, offset, call, ret, target,
        input  pc, sp, stack_full, stack_empty, fault
    );

    modport slave (
        input  stall, jump, branch, offset, call, ret, target,
        output pc, sp, stack_full, stack_empty, fault
    );
endinterface

// File: rtl/pc_sequencer_call_stack.sv
// Return-address LIFO. Push on full and pop on empty are ignored and
// flagged so the parent can record a fault. Entries are not reset; only
// the occupancy count is.
module call_stack #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          push_data,
    output logic [DATA_W-1:0]          top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       push_rej,
    output logic                       pop_rej
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [2**IDX_W];
    logic [CNT_W-1:0]  cnt_m1;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_rej = push && full;
    assign pop_rej  = pop && empty;
    assign cnt_m1   = count - CNT_W'(1);
    // Value at index count-1; meaningless while empty, callers check empty.
    assign top      = mem[cnt_m1[IDX_W-1:0]];

    // Occupancy: pop takes precedence, though the parent never asserts both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 count <= '0;
        else if (pop && !empty)  count <= cnt_m1;
        else if (push && !full)  count <= count + CNT_W'(1);
    end

    // Entry storage, written at the current occupancy index on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !full && !pop) mem[count[IDX_W-1:0]] <= push_data;
    end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: priority decode, next-PC mux, PC register and
// sticky fault flag, with a call_stack holding return addresses.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    pc_sel_e           sel;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] stack_top;
    logic [SP_W-1:0]   count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              push_rej;
    logic              pop_rej;
    logic              fault_q;

    // Resolve simultaneous controls down to a single action.
    always_comb sel = pc_select(bus.stall, bus.ret, bus.call, bus.jump, bus.branch);

    assign push   = (sel == SEL_CALL);
    assign pop    = (sel == SEL_RET);
    assign pc_inc = pc_q + ADDR_W'(1);

    call_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stack_top),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .push_rej  (push_rej),
        .pop_rej   (pop_rej)
    );

    // Next-PC mux; rejected call/ret fall through to a plain increment.
    always_comb begin
        pc_d = pc_inc;
        case (sel)
            SEL_HOLD:   pc_d = pc_q;
            SEL_RET:    pc_d = pop_rej ? pc_inc : stack_top;
            SEL_CALL:   pc_d = push_rej ? pc_inc : bus.target;
            SEL_JUMP:   pc_d = bus.target;
            SEL_BRANCH: pc_d = pc_q + bus.offset;
            default:    pc_d = pc_inc;
        endcase
    end

    // PC register and sticky fault; only reset clears the fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_ADDR;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_q | push_rej | pop_rej;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.sp          = count;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.fault       = fault_q;
endmodule
